// File: rtl/sc_fifo_pkg.sv
// sc_fifo_pkg: shared sizing and parameter-check helpers for sc_fifo_thresh.
package sc_fifo_pkg;

    // Capacity is the requested depth rounded up to a power of two (6 -> 8).
    function automatic int fifo_cap(input int words);
        return 1 << $clog2(words);
    endfunction

    // Almost-full must be reachable and non-zero; almost-empty must be below full.
    function automatic bit thresh_ok(input int af, input int ae, input int cap);
        return (af >= 1) && (af <= cap) && (ae >= 0) && (ae <= cap - 1);
    endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// sc_fifo_ram: DATA_WIDTH x 2**ADDR_WIDTH storage, synchronous write,
// asynchronous read so the FIFO head is visible in the same cycle.
module sc_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Store the incoming word at the write address.
    // NOTE: storage has no reset; contents are only ever read behind the
    // occupancy count, so clearing it would cost logic for no behaviour.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sc_fifo_thresh.sv
// sc_fifo_thresh: single-clock show-ahead FIFO with registered
// full/empty/almost-full/almost-empty flags.
// Optional macro SC_FIFO_THRESH_ERR_EN adds sticky overflow_o/underflow_o.
module sc_fifo_thresh
    import sc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WORDS_AMOUNT = 8,
    parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
    parameter int AF_THRESH    = fifo_cap(WORDS_AMOUNT) - 2,
    parameter int AE_THRESH    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [ADDR_WIDTH:0]   used_words_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
`ifdef SC_FIFO_THRESH_ERR_EN
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
`else
    output logic                  almost_empty_o
`endif
);

    localparam int FIFO_CAP = fifo_cap(WORDS_AMOUNT);

    localparam logic [ADDR_WIDTH:0]   CAP_CNT = (ADDR_WIDTH + 1)'(FIFO_CAP);
    localparam logic [ADDR_WIDTH:0]   AF_CNT  = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_CNT  = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    if (!thresh_ok(AF_THRESH, AE_THRESH, FIFO_CAP)) begin : g_bad_thresh
        $error("sc_fifo_thresh: illegal AF_THRESH=%0d / AE_THRESH=%0d for capacity %0d",
               AF_THRESH, AE_THRESH, FIFO_CAP);
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Qualify requests against the current flags and derive the next count.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        wr_acc     = wr_i && !full_o;
        rd_acc     = rd_i && !empty_o;
        count_next = used_words_o;
        if (wr_acc && !rd_acc) begin
            count_next = used_words_o + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_next = used_words_o - CNT_ONE;
        end
    end

    // Pointers, count and flags; flags are computed from the next count so
    // they never lag used_words_o.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            used_words_o   <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_empty_o <= 1'b1;
            almost_full_o  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            used_words_o   <= count_next;
            empty_o        <= (count_next == '0);
            full_o         <= (count_next == CAP_CNT);
            almost_empty_o <= (count_next <= AE_CNT);
            almost_full_o  <= (count_next >= AF_CNT);
        end
    end

`ifdef SC_FIFO_THRESH_ERR_EN
    // Sticky error flags for requests dropped at full or empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_i && full_o) begin
                overflow_o <= 1'b1;
            end
            if (rd_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end
`endif

    sc_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk_i),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data_i),
        .raddr (rd_ptr),
        .rdata (rd_data_o)
    );

endmodule

// File: tb/tb_sc_fifo_thresh.sv
// tb_sc_fifo_thresh: directed scoreboard bench for sc_fifo_thresh
// (8-deep instance with AF=6/AE=2, plus a WORDS_AMOUNT=6 instance).
module tb_sc_fifo_thresh;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic [7:0] rdata;
    logic [3:0] used;
    logic       full, empty, afull, aempty;

    logic       wr6;
    logic [7:0] wd6;
    logic       rd6;
    logic [7:0] rdata6;
    logic [3:0] used6;
    logic       full6, empty6, afull6, aempty6;

`ifdef SC_FIFO_THRESH_ERR_EN
    logic ovf, unf, ovf6, unf6;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [7:0] sb[$];
    int         m_count = 0;
    bit         m_ovf   = 1'b0;
    bit         m_unf   = 1'b0;

    always #5 clk = ~clk;

    sc_fifo_thresh #(
        .DATA_WIDTH   (8),
        .WORDS_AMOUNT (8),
        .AF_THRESH    (6),
        .AE_THRESH    (2)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_i           (wr),
        .wr_data_i      (wd),
        .rd_i           (rd),
        .rd_data_o      (rdata),
        .used_words_o   (used),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (afull),
`ifdef SC_FIFO_THRESH_ERR_EN
        .almost_empty_o (aempty),
        .overflow_o     (ovf),
        .underflow_o    (unf)
`else
        .almost_empty_o (aempty)
`endif
    );

    sc_fifo_thresh #(
        .DATA_WIDTH   (8),
        .WORDS_AMOUNT (6)
    ) u_dut6 (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_i           (wr6),
        .wr_data_i      (wd6),
        .rd_i           (rd6),
        .rd_data_o      (rdata6),
        .used_words_o   (used6),
        .full_o         (full6),
        .empty_o        (empty6),
        .almost_full_o  (afull6),
`ifdef SC_FIFO_THRESH_ERR_EN
        .almost_empty_o (aempty6),
        .overflow_o     (ovf6),
        .underflow_o    (unf6)
`else
        .almost_empty_o (aempty6)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output of the 8-deep instance against the model.
    task automatic check_state(input string ph);
        check({ph, " used"},   32'(used),   32'(m_count));
        check({ph, " empty"},  32'(empty),  32'(m_count == 0));
        check({ph, " full"},   32'(full),   32'(m_count == 8));
        check({ph, " afull"},  32'(afull),  32'(m_count >= 6));
        check({ph, " aempty"}, 32'(aempty), 32'(m_count <= 2));
        if (m_count != 0) begin
            check({ph, " head"}, 32'(rdata), 32'(sb[0]));
        end
`ifdef SC_FIFO_THRESH_ERR_EN
        check({ph, " overflow"},  32'(ovf), 32'(m_ovf));
        check({ph, " underflow"}, 32'(unf), 32'(m_unf));
`endif
    endtask

    // One clock of stimulus: drive at the falling edge, pop/compare the head
    // for an accepted read, update the model, then check after the edge.
    task automatic cycle(input string ph, input logic w, input logic [7:0] d, input logic r);
        bit acc_w, acc_r;
        logic [7:0] exp_head;
        @(negedge clk);
        wr = w;
        wd = d;
        rd = r;
        acc_w = w && (m_count != 8);
        acc_r = r && (m_count != 0);
        if (w && m_count == 8) m_ovf = 1'b1;
        if (r && m_count == 0) m_unf = 1'b1;
        if (acc_r) begin
            exp_head = sb.pop_front();
            check({ph, " read"}, 32'(rdata), 32'(exp_head));
        end
        if (acc_w) sb.push_back(d);
        m_count = m_count + int'(acc_w) - int'(acc_r);
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        check_state(ph);
    endtask

    initial begin
        rst = 1'b1;
        wr  = 1'b0;
        wd  = '0;
        rd  = 1'b0;
        wr6 = 1'b0;
        wd6 = '0;
        rd6 = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_state("reset");
        check("reset6 used",  32'(used6),  32'd0);
        check("reset6 empty", 32'(empty6), 32'd1);
        rst = 1'b0;

        // Fill 0x11..0x18: count, thresholds and show-ahead head.
        for (int i = 0; i < 8; i++) begin
            cycle("fill", 1'b1, 8'h11 + 8'(i), 1'b0);
        end

        // Full: simultaneous write (dropped) and read (accepted).
        cycle("full_wr_rd", 1'b1, 8'hAA, 1'b1);
        check("full_wr_rd count", 32'(used), 32'd7);
        check("full_wr_rd head", 32'(rdata), 32'h12);

        // Drain the rest in order, then one read on empty.
        for (int i = 0; i < 7; i++) begin
            cycle("drain", 1'b0, 8'h00, 1'b1);
        end
        check("drained empty", 32'(empty), 32'd1);
        cycle("underflow", 1'b0, 8'h00, 1'b1);

        // Half full, then 20 cycles of simultaneous read/write across wrap.
        for (int i = 0; i < 4; i++) begin
            cycle("half_fill", 1'b1, 8'h30 + 8'(i), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            cycle("stream", 1'b1, 8'h40 + 8'(i), 1'b1);
        end
        check("stream count", 32'(used), 32'd4);

        // Mid-stream reset at count 5 with a write request present.
        cycle("to_five", 1'b1, 8'h60, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        wr  = 1'b1;
        wd  = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr  = 1'b0;
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        check_state("mid_reset");
        cycle("post_reset_wr", 1'b1, 8'h71, 1'b0);
        cycle("post_reset_rd", 1'b0, 8'h00, 1'b1);

        // WORDS_AMOUNT=6 rounds to capacity 8 with default AF_THRESH=6.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            wr6 = 1'b1;
            wd6 = 8'h80 + 8'(i);
            @(posedge clk);
            #1;
            wr6 = 1'b0;
            check("cap6 used",  32'(used6),  32'(i));
            check("cap6 full",  32'(full6),  32'(i == 8));
            check("cap6 afull", 32'(afull6), 32'(i >= 6));
        end
        check("cap6 head", 32'(rdata6), 32'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
